memory_access_stage: RTL and testbench

Memory-access (MEM) stage of the five-stage RISC-V pipeline. It consumes the EX/MEM register (`MemoryAccessStagePipeReg`) and produces the MEM/WB register (`WriteBackStagePipeReg`). Loads and stores are issued to the data memory over a req/ack handshake with byte-lane alignment, and load data is sign- or zero-extended. Upstream stages are stalled while an access is outstanding.

---
 rtl/PipelineTypes.sv | 42 ++++
 rtl/load_store_align.sv | 48 ++++
 rtl/memory_access_stage.sv | 146 ++++++++++++++
 tb/tb_memory_access_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/PipelineTypes.sv
// Shared pipeline types for the EX/MEM and MEM/WB registers and the MEM-stage FSM.
package PipelineTypes;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } MemAccessWidth;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } MemStageState;

  typedef struct packed {
    logic       wr_en;
    logic [4:0] rd_addr;
  } RdCtrl;

  // mem_access_width is kept as a raw 2-bit field so the illegal 2'b11 encoding can arrive
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] irreg_pc;
    logic [31:0] alu_result;
    RdCtrl       rdCtrl;
    logic        is_load;
    logic        is_store;
    logic        is_load_unsigned;
    logic [1:0]  mem_access_width;
    logic [31:0] w_data;
  } MemoryAccessStagePipeReg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] irreg_pc;
    logic [31:0] alu_result;
    RdCtrl       rdCtrl;
    logic        is_load;
    logic [31:0] r_data;
  } WriteBackStagePipeReg;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane logic for data memory accesses: alignment check, byte enables,
// store-lane replication and load extraction with sign/zero extension.
module load_store_align
  import PipelineTypes::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  assign shifted = ld_word >> {addr_lo, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b0000;
    st_lanes   = st_data;
    ld_data    = shifted;
    case (width)
      MEM_BYTE: begin
        be       = 4'b0001 << addr_lo;
        st_lanes = {4{st_data[7:0]}};
        ld_data  = is_unsigned ? {24'h000000, shifted[7:0]}
                               : {{24{shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        misaligned = addr_lo[0];
        be         = 4'b0011 << addr_lo;
        st_lanes   = {2{st_data[15:0]}};
        ld_data    = is_unsigned ? {16'h0000, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      end
      MEM_WORD: begin
        misaligned = |addr_lo;
        be         = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// RISC-V MEM stage: issues loads/stores over a req/ack handshake, stalls upstream
// while an access is outstanding, and produces the MEM/WB register.
module memory_access_stage
  import PipelineTypes::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  MemoryAccessStagePipeReg in_reg,
  input  logic                    in_valid,
  output WriteBackStagePipeReg    out_reg,
  output logic                    out_valid,
  output logic                    stall,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [31:0]             dmem_addr,
  output logic [31:0]             dmem_wdata,
  output logic [3:0]              dmem_be,
  input  logic                    dmem_ack,
  input  logic [31:0]             dmem_rdata,
  output logic                    misaligned,
  output logic                    timeout
);

  localparam int CNT_W = $clog2(TIMEOUT);

  MemStageState     state_p1, state_nxt;
  logic [CNT_W-1:0] cnt_p1;

  logic [31:0] pc_p1, irreg_pc_p1, alu_p1, wdata_p1;
  RdCtrl       rd_ctrl_p1;
  logic        is_load_p1, uns_p1, we_p1;
  logic [1:0]  width_p1;
  logic [3:0]  be_p1;

  logic        busy, is_mem, accept, to_hit;
  logic        al_mis;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign busy   = (state_p1 == BUSY);
  assign is_mem = in_reg.is_load | in_reg.is_store;
  assign accept = !busy && in_valid && is_mem && !al_mis;
  assign to_hit = busy && !dmem_ack && (cnt_p1 == CNT_W'(TIMEOUT - 1));

  // In IDLE the aligner sees the incoming op; in BUSY it sees the latched one for load extraction
  load_store_align u_align (
    .addr_lo     (busy ? alu_p1[1:0] : in_reg.alu_result[1:0]),
    .width       (busy ? width_p1 : in_reg.mem_access_width),
    .is_unsigned (uns_p1),
    .st_data     (in_reg.w_data),
    .ld_word     (dmem_rdata),
    .misaligned  (al_mis),
    .be          (al_be),
    .st_lanes    (al_wdata),
    .ld_data     (al_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_p1 <= IDLE;
    else     state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (dmem_ack || to_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall     = busy;
    dmem_req  = busy;
    dmem_we   = busy & we_p1;
    dmem_be   = busy ? be_p1 : 4'b0000;
  end

  assign dmem_addr  = {alu_p1[31:2], 2'b00};
  assign dmem_wdata = wdata_p1;

  // Stage boundary: latched request, wait counter and MEM/WB register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p1      <= '0;
      pc_p1       <= '0;
      irreg_pc_p1 <= '0;
      alu_p1      <= '0;
      wdata_p1    <= '0;
      rd_ctrl_p1  <= '0;
      is_load_p1  <= 1'b0;
      uns_p1      <= 1'b0;
      we_p1       <= 1'b0;
      width_p1    <= 2'b00;
      be_p1       <= 4'b0000;
      out_reg     <= '0;
      out_valid   <= 1'b0;
      misaligned  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
      if (!busy) begin
        if (in_valid && !is_mem) begin
          out_reg.pc         <= in_reg.pc;
          out_reg.irreg_pc   <= in_reg.irreg_pc;
          out_reg.alu_result <= in_reg.alu_result;
          out_reg.rdCtrl     <= in_reg.rdCtrl;
          out_reg.is_load    <= 1'b0;
          out_reg.r_data     <= '0;
          out_valid          <= 1'b1;
        end else if (in_valid && al_mis) begin
          misaligned <= 1'b1;
        end else if (accept) begin
          pc_p1       <= in_reg.pc;
          irreg_pc_p1 <= in_reg.irreg_pc;
          alu_p1      <= in_reg.alu_result;
          rd_ctrl_p1  <= in_reg.rdCtrl;
          is_load_p1  <= in_reg.is_load;
          uns_p1      <= in_reg.is_load_unsigned;
          width_p1    <= in_reg.mem_access_width;
          we_p1       <= in_reg.is_store;
          be_p1       <= al_be;
          wdata_p1    <= al_wdata;
          cnt_p1      <= '0;
        end
      end else if (dmem_ack) begin
        out_reg.pc         <= pc_p1;
        out_reg.irreg_pc   <= irreg_pc_p1;
        out_reg.alu_result <= alu_p1;
        out_reg.rdCtrl     <= rd_ctrl_p1;
        out_reg.is_load    <= is_load_p1;
        out_reg.r_data     <= is_load_p1 ? al_rdata : 32'h0000_0000;
        out_valid          <= 1'b1;
      end else if (to_hit) begin
        timeout <= 1'b1;
      end else begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage with a transaction-level reference model.
module tb_memory_access_stage;
  import PipelineTypes::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  MemoryAccessStagePipeReg in_reg;
  logic in_valid;
  WriteBackStagePipeReg out_reg;
  logic out_valid, stall, dmem_req, dmem_we, dmem_ack, misaligned, timeout;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_be;

  memory_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_reg(in_reg), .in_valid(in_valid),
    .out_reg(out_reg), .out_valid(out_valid), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .misaligned(misaligned), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int req_cnt = 0;
  int stall_cnt = 0;

  logic chk_en = 1'b0;
  logic e_req, e_we, e_stall, e_ov, e_mis, e_to, e_chk_dm;
  logic [3:0] e_be;
  logic [31:0] e_addr, e_wdata;
  WriteBackStagePipeReg e_out;
  logic lit_on = 1'b0;
  logic [3:0] lit_be;
  logic [31:0] lit_addr, lit_wdata;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [1:0] w, input logic [1:0] a);
    if (w == 2'd0) return 4'(1 << a);
    if (w == 2'd1) return 4'(3 << a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] d);
    if (w == 2'd0) return (d % 256) * 32'h0101_0101;
    if (w == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] w, input logic [1:0] a,
                                         input logic uns, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * a);
    if (w == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic bit legal(input logic [1:0] w, input logic [1:0] a);
    return (w == 2'd0) || (w == 2'd1 && a % 2 == 0) || (w == 2'd2 && a == 2'd0);
  endfunction

  function automatic MemoryAccessStagePipeReg rand_reg();
    MemoryAccessStagePipeReg r;
    r.pc               = $urandom;
    r.irreg_pc         = $urandom;
    r.alu_result       = $urandom;
    r.rdCtrl           = 6'($urandom);
    r.is_load          = 1'b0;
    r.is_store         = 1'b0;
    r.is_load_unsigned = 1'($urandom);
    r.mem_access_width = 2'($urandom);
    r.w_data           = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle(input logic ov, input logic mis, input logic to);
    e_req = 1'b0; e_we = 1'b0; e_be = 4'h0; e_stall = 1'b0;
    e_ov = ov; e_mis = mis; e_to = to; e_chk_dm = 1'b0;
  endtask

  task automatic set_reset_exp();
    set_idle(1'b0, 1'b0, 1'b0);
    e_chk_dm = 1'b1; e_addr = 32'h0; e_wdata = 32'h0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (dmem_req) req_cnt++;
      if (stall) stall_cnt++;
      cmp("dmem_req", 32'(dmem_req), 32'(e_req));
      cmp("dmem_we", 32'(dmem_we), 32'(e_we));
      cmp("dmem_be", 32'(dmem_be), 32'(e_be));
      cmp("stall", 32'(stall), 32'(e_stall));
      cmp("out_valid", 32'(out_valid), 32'(e_ov));
      cmp("misaligned", 32'(misaligned), 32'(e_mis));
      cmp("timeout", 32'(timeout), 32'(e_to));
      if (e_chk_dm) begin
        cmp("dmem_addr", dmem_addr, e_addr);
        cmp("dmem_wdata", dmem_wdata, e_wdata);
      end
      if (lit_on && e_req) begin
        cmp("lit_be", 32'(dmem_be), 32'(lit_be));
        cmp("lit_addr", dmem_addr, lit_addr);
        cmp("lit_wdata", dmem_wdata, lit_wdata);
      end
      if (e_ov) begin
        cmp("out_pc", out_reg.pc, e_out.pc);
        cmp("out_irreg_pc", out_reg.irreg_pc, e_out.irreg_pc);
        cmp("out_alu", out_reg.alu_result, e_out.alu_result);
        cmp("out_rdctrl", 32'(out_reg.rdCtrl), 32'(e_out.rdCtrl));
        cmp("out_is_load", 32'(out_reg.is_load), 32'(e_out.is_load));
        cmp("out_r_data", out_reg.r_data, e_out.r_data);
      end
    end
  end

  // One instruction through the stage; ack_at = BUSY cycle index of the ack (-1: never),
  // rst_at = BUSY cycle index at which reset is asserted (-1: never).
  task automatic issue(input MemoryAccessStagePipeReg r, input int ack_at,
                       input logic [31:0] rd, input int rst_at);
    logic [1:0] a, w;
    a = r.alu_result[1:0];
    w = r.mem_access_width;
    in_reg = r; in_valid = 1'b1;
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    step();
    in_valid = 1'b0; in_reg = rand_reg(); dmem_ack = 1'b0;
    e_out.pc = r.pc; e_out.irreg_pc = r.irreg_pc; e_out.alu_result = r.alu_result;
    e_out.rdCtrl = r.rdCtrl; e_out.is_load = r.is_load; e_out.r_data = 32'h0;
    if (!(r.is_load || r.is_store)) begin
      e_out.is_load = 1'b0;
      set_idle(1'b1, 1'b0, 1'b0);
    end else if (!legal(w, a)) begin
      set_idle(1'b0, 1'b1, 1'b0);
    end else begin
      e_req = 1'b1; e_stall = 1'b1; e_ov = 1'b0; e_mis = 1'b0; e_to = 1'b0;
      e_we = r.is_store; e_be = m_be(w, a);
      e_addr = {r.alu_result[31:2], 2'b00}; e_wdata = m_wdata(w, r.w_data); e_chk_dm = 1'b1;
      for (int i = 0; i < TO; i++) begin
        if (i == rst_at) begin
          rst = 1'b1;
          #1;
          cmp("rst_req_now", 32'(dmem_req), 32'h0);
          cmp("rst_stall_now", 32'(stall), 32'h0);
          cmp("rst_valid_now", 32'(out_valid), 32'h0);
          cmp("rst_out_rdata", out_reg.r_data, 32'h0);
          set_reset_exp();
          step();
          rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = $urandom;
          step();
          dmem_ack = 1'b0;
          return;
        end
        if (i == ack_at) begin
          dmem_ack = 1'b1; dmem_rdata = rd;
          step();
          dmem_ack = 1'b0;
          if (r.is_load) e_out.r_data = m_load(w, a, r.is_load_unsigned, rd);
          set_idle(1'b1, 1'b0, 1'b0);
          return;
        end
        if (i == TO - 1) begin
          step();
          set_idle(1'b0, 1'b0, 1'b1);
          return;
        end
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        step();
      end
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0; in_reg = rand_reg(); dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    step();
    dmem_ack = 1'b0;
    set_idle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    MemoryAccessStagePipeReg r;
    int ack_at, rst_at, kind;

    in_valid = 1'b0; in_reg = '0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    e_out = '0;
    set_reset_exp();
    step(); step();
    chk_en = 1'b1;
    cmp("rst_out_pc", out_reg.pc, 32'h0);
    cmp("rst_out_alu", out_reg.alu_result, 32'h0);
    step();
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ack = 1'b0;
    step();

    // non-memory pass-through
    r = rand_reg(); r.pc = 32'h100; r.alu_result = 32'h1234;
    req_cnt = 0;
    issue(r, 0, 32'h0, -1);
    @(negedge clk);
    cmp("nm_alu", out_reg.alu_result, 32'h1234);
    cmp("nm_pc", out_reg.pc, 32'h100);
    cmp("nm_valid", 32'(out_valid), 32'h1);
    cmp("nm_req_cnt", 32'(req_cnt), 32'h0);

    // sb at 0x1003, ack in the third BUSY cycle
    r = rand_reg(); r.is_store = 1'b1; r.alu_result = 32'h1003; r.mem_access_width = 2'b00;
    r.w_data = 32'h0000_00AB;
    lit_on = 1'b1; lit_be = 4'b1000; lit_addr = 32'h1000; lit_wdata = 32'hABAB_ABAB;
    stall_cnt = 0;
    issue(r, 2, 32'h0, -1);
    lit_on = 1'b0;
    @(negedge clk);
    cmp("sb_stall_cycles", 32'(stall_cnt), 32'd3);
    cmp("sb_valid", 32'(out_valid), 32'h1);

    // lh / lhu at 0x2002
    r = rand_reg(); r.is_load = 1'b1; r.alu_result = 32'h2002; r.mem_access_width = 2'b01;
    r.is_load_unsigned = 1'b0;
    issue(r, 0, 32'h8001_0000, -1);
    @(negedge clk);
    cmp("lh_rdata", out_reg.r_data, 32'hFFFF_8001);
    r.is_load_unsigned = 1'b1;
    issue(r, 0, 32'h8001_0000, -1);
    @(negedge clk);
    cmp("lhu_rdata", out_reg.r_data, 32'h0000_8001);

    // lw at 0x2002 is misaligned; next op accepted in the pulse cycle
    r = rand_reg(); r.is_load = 1'b1; r.alu_result = 32'h2002; r.mem_access_width = 2'b10;
    req_cnt = 0;
    issue(r, 0, 32'h0, -1);
    @(negedge clk);
    cmp("lw_mis_pulse", 32'(misaligned), 32'h1);
    cmp("lw_mis_valid", 32'(out_valid), 32'h0);
    r = rand_reg(); r.pc = 32'h300;
    issue(r, 0, 32'h0, -1);
    @(negedge clk);
    cmp("after_mis_pc", out_reg.pc, 32'h300);
    cmp("lw_mis_req_cnt", 32'(req_cnt), 32'h0);

    // lb with no ack times out; ack on the last BUSY cycle wins
    r = rand_reg(); r.is_load = 1'b1; r.mem_access_width = 2'b00;
    req_cnt = 0;
    issue(r, -1, 32'h0, -1);
    @(negedge clk);
    cmp("to_pulse", 32'(timeout), 32'h1);
    cmp("to_stall", 32'(stall), 32'h0);
    cmp("to_valid", 32'(out_valid), 32'h0);
    cmp("to_req_cycles", 32'(req_cnt), 32'd16);
    issue(r, TO - 1, 32'h0000_0080, -1);
    @(negedge clk);
    cmp("late_ack_no_to", 32'(timeout), 32'h0);
    cmp("late_ack_valid", 32'(out_valid), 32'h1);

    // reset in the middle of BUSY
    r = rand_reg(); r.is_load = 1'b1; r.mem_access_width = 2'b10; r.alu_result[1:0] = 2'b00;
    issue(r, -1, 32'h0, 3);

    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 19));
      if (kind < 2) begin
        idle_cycle();
      end else begin
        r = rand_reg();
        if (kind < 6) begin
        end else if (kind < 13) r.is_load = 1'b1;
        else r.is_store = 1'b1;
        if ($urandom_range(0, 3) != 0 && r.mem_access_width == 2'b11)
          r.mem_access_width = 2'($urandom_range(0, 2));
        ack_at = int'($urandom_range(0, 4));
        rst_at = -1;
        case ($urandom_range(0, 15))
          0: ack_at = -1;
          1: ack_at = TO - 1;
          2: begin ack_at = -1; rst_at = int'($urandom_range(0, 3)); end
          default: ;
        endcase
        issue(r, ack_at, $urandom, rst_at);
      end
    end
    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
